// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC source selects and default vectors.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    PC_SRC_SEQ  = 3'd0,
    PC_SRC_BR   = 3'd1,
    PC_SRC_RET  = 3'd2,
    PC_SRC_CALL = 3'd3,
    PC_SRC_JMP  = 3'd4,
    PC_SRC_EXC  = 3'd5,
    PC_SRC_HOLD = 3'd6
  } pc_src_e;

  localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'd0;
  localparam logic [31:0] PC_EXC_VEC_DEFAULT   = 32'd1;

endpackage

// File: rtl/pc_unit_if.sv
// Redirect requests into the PC unit and PC/RAS status out of it.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             exc;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic [WIDTH-1:0] jump_target;
  logic             ret;
  logic [WIDTH-1:0] ret_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, exc, branch_taken, branch_target, jump, call, jump_target, ret, ret_target,
    input  pc, pc_plus, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, exc, branch_taken, branch_target, jump, call, jump_target, ret, ret_target,
    output pc, pc_plus, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_unit_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_top_idx;

  // r_ptr is the next free slot, so the top lives one below it (mod DEPTH).
  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) r_cnt <= r_cnt + CW'(1);
    end else if (i_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC selection and a return-address stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC_DEFAULT),
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  pc_unit_if.slave io_pc
);
  logic [WIDTH-1:0] r_pc;
  logic             r_underflow;
  pc_src_e          w_sel;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow_nxt;

  assign w_pc_plus = r_pc + WIDTH'(STEP);

  always_comb begin
    w_sel = PC_SRC_SEQ;
    if (io_pc.exc)               w_sel = PC_SRC_EXC;
    else if (io_pc.stall)        w_sel = PC_SRC_HOLD;
    else if (io_pc.branch_taken) w_sel = PC_SRC_BR;
    else if (io_pc.ret)          w_sel = PC_SRC_RET;
    else if (io_pc.call)         w_sel = PC_SRC_CALL;
    else if (io_pc.jump)         w_sel = PC_SRC_JMP;
  end

  always_comb begin
    w_next_pc       = w_pc_plus;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_underflow_nxt = 1'b0;
    case (w_sel)
      PC_SRC_EXC:  w_next_pc = EXC_VEC;
      PC_SRC_HOLD: begin
        w_next_pc       = r_pc;
        w_underflow_nxt = r_underflow;
      end
      PC_SRC_BR:   w_next_pc = io_pc.branch_target;
      PC_SRC_RET: begin
        // Fall back to the register-file $ra when the stack has nothing to offer.
        if (w_ras_empty) begin
          w_next_pc       = io_pc.ret_target;
          w_underflow_nxt = 1'b1;
        end else begin
          w_next_pc = w_ras_top;
          w_pop     = 1'b1;
        end
      end
      PC_SRC_CALL: begin
        w_next_pc = io_pc.jump_target;
        w_push    = 1'b1;
      end
      PC_SRC_JMP:  w_next_pc = io_pc.jump_target;
      default:     w_next_pc = w_pc_plus;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc        <= RESET_VEC;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_underflow <= w_underflow_nxt;
    end
  end

  pc_unit_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_dat (w_pc_plus),
    .o_top      (w_ras_top),
    .o_empty    (w_ras_empty),
    .o_full     (w_ras_full)
  );

  assign io_pc.pc            = r_pc;
  assign io_pc.pc_plus       = w_pc_plus;
  assign io_pc.ras_empty     = w_ras_empty;
  assign io_pc.ras_full      = w_ras_full;
  assign io_pc.ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, stall, priority, RAS wrap/underflow, PC wrap and reset.
module tb_pc_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pc_unit_if #(.WIDTH(32)) u_if ();

  pc_unit #(
    .WIDTH     (32),
    .RESET_VEC (32'd0),
    .EXC_VEC   (32'd1),
    .STEP      (1),
    .RAS_DEPTH (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_pc (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    u_if.stall = 1'b0;  u_if.exc = 1'b0;
    u_if.branch_taken = 1'b0; u_if.branch_target = '0;
    u_if.jump = 1'b0;   u_if.call = 1'b0; u_if.jump_target = '0;
    u_if.ret = 1'b0;    u_if.ret_target = '0;

    // Reset state
    #12;
    chk("rst_pc", u_if.pc, 32'd0);
    chk("rst_empty", {31'd0, u_if.ras_empty}, 32'd1);
    chk("rst_full", {31'd0, u_if.ras_full}, 32'd0);
    chk("rst_uflow", {31'd0, u_if.ras_underflow}, 32'd0);
    chk("rst_pc_plus", u_if.pc_plus, 32'd1);
    rst = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("seq_pc", u_if.pc, 32'(i));
    end
    chk("seq_empty", {31'd0, u_if.ras_empty}, 32'd1);

    // Stall with a pending jump, then release
    u_if.stall = 1'b1; u_if.jump = 1'b1; u_if.jump_target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", u_if.pc, 32'd7);
    end
    u_if.stall = 1'b0;
    tick();
    chk("jump_pc", u_if.pc, 32'h40);
    u_if.jump = 1'b0;

    // Branch beats ret; exc beats stall
    u_if.branch_taken = 1'b1; u_if.branch_target = 32'h100;
    u_if.ret = 1'b1; u_if.ret_target = 32'h55;
    tick();
    chk("br_pc", u_if.pc, 32'h100);
    chk("br_empty", {31'd0, u_if.ras_empty}, 32'd1);
    chk("br_uflow", {31'd0, u_if.ras_underflow}, 32'd0);
    u_if.branch_taken = 1'b0; u_if.ret = 1'b0;
    u_if.exc = 1'b1; u_if.stall = 1'b1;
    tick();
    chk("exc_pc", u_if.pc, 32'd1);
    u_if.exc = 1'b0; u_if.stall = 1'b0;

    // Five calls into a depth-4 RAS
    u_if.jump = 1'b1; u_if.jump_target = 32'd10;
    tick();
    chk("pre_call_pc", u_if.pc, 32'd10);
    u_if.jump = 1'b0; u_if.call = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      u_if.jump_target = 32'(i * 10);
      tick();
      chk("call_pc", u_if.pc, 32'(i * 10));
    end
    chk("call4_full", {31'd0, u_if.ras_full}, 32'd1);
    u_if.jump_target = 32'h200;
    tick();
    chk("call5_pc", u_if.pc, 32'h200);
    chk("call5_full", {31'd0, u_if.ras_full}, 32'd1);
    u_if.call = 1'b0; u_if.ret = 1'b1; u_if.ret_target = 32'h77;
    tick();
    chk("ret1_pc", u_if.pc, 32'd51);
    chk("ret1_full", {31'd0, u_if.ras_full}, 32'd0);
    tick();
    chk("ret2_pc", u_if.pc, 32'd41);
    tick();
    chk("ret3_pc", u_if.pc, 32'd31);
    chk("ret3_empty", {31'd0, u_if.ras_empty}, 32'd0);
    tick();
    chk("ret4_pc", u_if.pc, 32'd21);
    chk("ret4_empty", {31'd0, u_if.ras_empty}, 32'd1);
    chk("ret4_uflow", {31'd0, u_if.ras_underflow}, 32'd0);

    // Return with empty RAS
    u_if.ret_target = 32'h2A;
    tick();
    chk("uflow_pc", u_if.pc, 32'h2A);
    chk("uflow_set", {31'd0, u_if.ras_underflow}, 32'd1);
    u_if.ret = 1'b0;
    tick();
    chk("uflow_next_pc", u_if.pc, 32'h2B);
    chk("uflow_clr", {31'd0, u_if.ras_underflow}, 32'd0);

    // PC wrap at all-ones
    u_if.jump = 1'b1; u_if.jump_target = 32'hFFFF_FFFF;
    tick();
    chk("wrap_pre", u_if.pc, 32'hFFFF_FFFF);
    chk("wrap_plus", u_if.pc_plus, 32'd0);
    u_if.jump = 1'b0;
    tick();
    chk("wrap_pc", u_if.pc, 32'd0);

    // Asynchronous reset in the middle of a call sequence
    u_if.call = 1'b1; u_if.jump_target = 32'h300;
    tick();
    chk("mid_call_pc", u_if.pc, 32'h300);
    chk("mid_call_empty", {31'd0, u_if.ras_empty}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pc", u_if.pc, 32'd0);
    chk("async_rst_empty", {31'd0, u_if.ras_empty}, 32'd1);
    #2 rst = 1'b0;
    u_if.call = 1'b0;
    tick();
    chk("post_rst_pc", u_if.pc, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
